vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single video RAM between the CPU and the VGA scan-out path, one 8-pixel character cell at a time.
- Tracks cell phase from the timing generator's shload_n, drives that generator's oe_n (vga_oe_n) in the video slot, and gives the CPU a fixed slot per cell in active display and free access in vertical blanking.
- Sits between the CPU bus interface, the timing generator and the VRAM chip-select/strobe pins.

Parameters:
- ADDR_W, 15, VRAM address width
- DATA_W, 8, VRAM data width
- CPU_STROBE, 2, cycles ram_oe_n/ram_we_n held low in a CPU access (1..2 legal)

Ports:
- pclk  input  1  pixel clock
- rst  input  1  asynchronous reset, active-high
- shload_n  input  1  cell-end marker from timing generator, low on last pixel of cell
- vblank_n  input  1  low during vertical blanking
- vga_oe_n  output  1  enables timing generator's col/row onto VRAM address bus
- vid_latch  output  1  one-cycle pulse; video data valid on VRAM bus
- cpu_req  input  1  CPU access request, held until cpu_ready
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_W  CPU address
- cpu_wdata  input  DATA_W  CPU write data
- cpu_rdata  output  DATA_W  registered read data
- cpu_ready  output  1  one-cycle completion pulse
- ram_addr  output  ADDR_W  CPU address to VRAM, driven only when cpu_bus_oe=1, else high-Z
- ram_data  inout  DATA_W  VRAM data; driven with cpu_wdata only in write STROBE
- cpu_bus_oe  output  1  CPU owns VRAM address bus
- ram_ce_n  output  1  VRAM chip enable
- ram_oe_n  output  1  VRAM output enable
- ram_we_n  output  1  VRAM write enable
- sync_err  output  1  one-cycle pulse on misaligned shload_n

Behaviour:
- Reset (asynchronous, any time, incl. mid-access): phase=0, state=IDLE; vga_oe_n=1, ram_ce_n=1, ram_oe_n=1, ram_we_n=1, cpu_bus_oe=0, cpu_ready=0, vid_latch=0, sync_err=0, cpu_rdata=0; ram_addr and ram_data high-Z.
- Phase: 3-bit counter, +1 per pclk. shload_n low forces phase=0 next cycle. shload_n low while phase!=7 is a misalignment: pulse sync_err.
- Active display (vblank_n=1):
  - Phases 0..3: video slot. vga_oe_n=0, ram_ce_n=0, ram_oe_n=0, cpu_bus_oe=0.
  - vid_latch pulses at phase 3.
  - Phases 4..7: CPU window.
- Vertical blanking (vblank_n=0): no video slot; vga_oe_n=1; CPU may start on any phase.
- vblank_n is sampled at phase 0 and held for the whole cell.
- CPU FSM states: IDLE, ADDR, STROBE, DONE.
- IDLE->ADDR: cpu_req=1 and start allowed. Start is allowed at phase 4 in active display, or on any cycle in blanking. cpu_addr, cpu_we and cpu_wdata are captured at this transition.
- ADDR (1 cycle): cpu_bus_oe=1, ram_ce_n=0, strobes high.
- STROBE (CPU_STROBE cycles):
  - Read: ram_oe_n=0; cpu_rdata captured on the last STROBE cycle.
  - Write: ram_we_n=0 and ram_data driven.
- DONE (1 cycle): strobes high, cpu_bus_oe=1, cpu_ready=1. Next state IDLE.
- Timing: an active-display access runs phases 4..4+CPU_STROBE+1 and ends by phase 7. Request-to-ready latency is 2+CPU_STROBE cycles from start.
- cpu_req dropped mid-access: the access completes and cpu_ready still pulses. Only one access is in flight at a time.
- cpu_req at phases 5..7 in active display waits for the next phase 4, or for the first cycle of blanking.
- Misaligned shload_n during ADDR/STROBE: abort to IDLE, deassert all strobes the next cycle, no cpu_ready. The request is retried at the next legal start.
- vblank 1->0 edge: takes effect at the next phase 0. Blanking to active is the same.

Optional Feature:
- VRAM_ARB_VBLANK_ONLY_EN defined: CPU starts only while vblank_n=0. Phases 4..7 in active display stay idle; requests wait for blanking. Tear-free updates.
- Undefined: behaviour as above.

Test Plan:
- Reset release, vblank_n=1, shload_n every 8 cycles, no cpu_req:
  - vga_oe_n low on phases 0..3 of every cell, vid_latch at phase 3.
  - ram_we_n never low; sync_err never pulses.
- Active display, read 0x1234 requested at phase 1, CPU_STROBE=2:
  - ADDR at phase 4, ram_oe_n low phases 5..6, cpu_ready at phase 7.
  - cpu_rdata = RAM model value; vga_oe_n=1 throughout.
- Blanking, back-to-back writes 0x55->0x0000 and 0xAA->0x0001:
  - Each takes 4 cycles, with 1 idle cycle between accesses.
  - RAM model holds both bytes; ram_addr high-Z between accesses.
- Misaligned shload_n injected during a write's STROBE:
  - sync_err pulses, ram_we_n returns high within 1 cycle, no cpu_ready.
  - Write retried at next phase 4, then cpu_ready.
- rst asserted mid-STROBE:
  - All ram_* strobes high and buses high-Z immediately; phase=0 after release.
- VRAM_ARB_VBLANK_ONLY_EN defined, request in active line:
  - No ADDR until vblank_n=0; cpu_ready 4 cycles after the first blanking phase 0.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: time-slices one VRAM between VGA scan-out and the CPU, per 8-pixel cell.
// Define VRAM_ARB_VBLANK_ONLY_EN to confine CPU accesses to vertical blanking.
module vram_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int CPU_STROBE = 2
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              shload_n,
  input  logic              vblank_n,
  output logic              vga_oe_n,
  output logic              vid_latch,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output wire  [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              cpu_bus_oe,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              sync_err
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    STROBE,
    DONE
  } state_t;

  localparam logic [1:0] LAST = 2'(CPU_STROBE - 1);

  state_t              state_q, state_d;
  logic [2:0]          phase_q, phase_d;
  logic                act_q, act_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                misalign, start_ok, abort;
  logic                vid, busy, strb;

  logic vga_oe_n_q, vid_latch_q, ready_q, bus_oe_q;
  logic ce_n_q, oe_n_q, we_n_q, drv_q, sync_err_q;

  always_comb begin
    misalign = !shload_n && (phase_q != 3'd7);
    phase_d  = shload_n ? phase_q + 3'd1 : 3'd0;
    // display mode is latched on entry to phase 0 and held all cell
    act_d    = (phase_d == 3'd0) ? vblank_n : act_q;
`ifdef VRAM_ARB_VBLANK_ONLY_EN
    start_ok = !act_q && !act_d;
`else
    start_ok = act_q ? (phase_d == 3'd4) : !act_d;
`endif
    // a CPU access must never overlap an active video slot
    abort    = misalign || (act_d && phase_d == 3'd0);

    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_req && start_ok) begin
          state_d = ADDR;
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
        end
      end
      ADDR: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = STROBE;
          cnt_d   = 2'd0;
        end
      end
      STROBE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          state_d = DONE;
          if (!we_q) rdata_d = ram_data;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    vid  = act_d && !phase_d[2];
    busy = state_d != IDLE;
    strb = state_d == STROBE;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= 3'd0;
      act_q       <= 1'b0;
      cnt_q       <= 2'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      vga_oe_n_q  <= 1'b1;
      vid_latch_q <= 1'b0;
      ready_q     <= 1'b0;
      bus_oe_q    <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      drv_q       <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      act_q       <= act_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      vga_oe_n_q  <= !vid;
      vid_latch_q <= act_d && (phase_d == 3'd3);
      ready_q     <= state_d == DONE;
      bus_oe_q    <= busy;
      ce_n_q      <= !(vid || busy);
      oe_n_q      <= !(vid || (strb && !we_d));
      we_n_q      <= !(strb && we_d);
      drv_q       <= strb && we_d;
      sync_err_q  <= misalign;
    end
  end

  assign vga_oe_n   = vga_oe_n_q;
  assign vid_latch  = vid_latch_q;
  assign cpu_ready  = ready_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_bus_oe = bus_oe_q;
  assign ram_ce_n   = ce_n_q;
  assign ram_oe_n   = oe_n_q;
  assign ram_we_n   = we_n_q;
  assign sync_err   = sync_err_q;
  assign ram_addr   = bus_oe_q ? addr_q : 'z;
  assign ram_data   = drv_q ? wdata_q : 'z;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed + random bench with a cell-timeline reference model
// and a behavioural VRAM chip on the tri-state bus.
module tb_vram_arbiter;

  localparam int S = 2;

  logic        pclk = 1'b0;
  logic        rst, shload_n, vblank_n;
  logic        cpu_req, cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        vga_oe_n, vid_latch, cpu_ready, cpu_bus_oe;
  logic        ram_ce_n, ram_oe_n, ram_we_n, sync_err;
  logic [7:0]  cpu_rdata;
  wire  [14:0] ram_addr;
  wire  [7:0]  ram_data;

  logic [7:0]  chip [0:32767];
  logic [7:0]  refm [0:32767];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // reference model: cell phase, latched display mode, access offset k
  int          m_ph;
  bit          m_act;
  bit          m_mis;
  int          m_k;
  bit          m_we;
  logic [14:0] m_addr;
  logic [7:0]  m_wd;
  logic [7:0]  m_rd;

  always #5 pclk = ~pclk;

  assign ram_data = (!ram_ce_n && !ram_oe_n && ram_we_n && cpu_bus_oe)
                  ? chip[ram_addr] : 'z;

  vram_arbiter #(.ADDR_W(15), .DATA_W(8), .CPU_STROBE(S)) dut (
    .pclk(pclk), .rst(rst), .shload_n(shload_n), .vblank_n(vblank_n),
    .vga_oe_n(vga_oe_n), .vid_latch(vid_latch),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ram_addr(ram_addr), .ram_data(ram_data), .cpu_bus_oe(cpu_bus_oe),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .sync_err(sync_err)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ph = 0; m_act = 0; m_mis = 0; m_k = -1; m_rd = 8'h00;
  endtask

  function automatic bit may_start(int nph, bit nact);
`ifdef VRAM_ARB_VBLANK_ONLY_EN
    return !m_act && !nact;
`else
    // active display: first CPU cycle is phase 4; blanking: any blanking cycle
    return m_act ? (nph == 4) : !nact;
`endif
  endfunction

  task automatic m_advance();
    int nph;
    bit nact, mis;
    nph  = shload_n ? (m_ph + 1) % 8 : 0;
    mis  = !shload_n && m_ph != 7;
    nact = (nph == 0) ? vblank_n : m_act;
    if (m_k >= 0) begin
      if (m_k <= S && (mis || (nph == 0 && nact))) m_k = -1;
      else if (m_k == S + 1) m_k = -1;
      else begin
        m_k++;
        if (m_k == S + 1) begin
          if (m_we) refm[m_addr] = m_wd;
          else m_rd = refm[m_addr];
        end
      end
    end else if (cpu_req && may_start(nph, nact)) begin
      m_k = 0; m_we = cpu_we; m_addr = cpu_addr; m_wd = cpu_wdata;
    end
    m_ph = nph; m_act = nact; m_mis = mis;
  endtask

  task automatic check();
    bit vid, stb;
    vid = m_act && m_ph < 4;
    stb = m_k >= 1 && m_k <= S;
    chk("vga_oe_n", vga_oe_n, !vid);
    chk("vid_latch", vid_latch, m_act && m_ph == 3);
    chk("cpu_bus_oe", cpu_bus_oe, m_k >= 0);
    chk("ram_ce_n", ram_ce_n, !(vid || m_k >= 0));
    chk("ram_oe_n", ram_oe_n, !(vid || (stb && !m_we)));
    chk("ram_we_n", ram_we_n, !(stb && m_we));
    chk("cpu_ready", cpu_ready, m_k == S + 1);
    chk("sync_err", sync_err, m_mis);
    chk("cpu_rdata", cpu_rdata, m_rd);
  endtask

  task automatic step();
    bit          wr;
    logic [14:0] wa;
    logic [7:0]  wd;
    wr = (ram_we_n === 1'b0) && (ram_ce_n === 1'b0);
    wa = ram_addr;
    wd = ram_data;
    @(posedge pclk);
    #1;
    cyc++;
    if (wr) chip[wa] = wd;
    if (rst) m_reset();
    else m_advance();
    check();
  endtask

  task automatic tick();
    shload_n = (m_ph != 7);
    step();
  endtask

  task automatic req(bit we, logic [14:0] a, logic [7:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    int c0, c1, r1, r2;
    bit got, seen;
    for (int i = 0; i < 32768; i++) begin
      chip[i] = 8'(i * 37 + 11);
      refm[i] = chip[i];
    end
    chip[15'h1234] = 8'h5A;
    refm[15'h1234] = 8'h5A;
    rst = 1'b1; shload_n = 1'b1; vblank_n = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    m_reset();
    repeat (3) step();
    rst = 1'b0;

    // idle active display: video slots only
    repeat (24) tick();

`ifndef VRAM_ARB_VBLANK_ONLY_EN
    // active-display read requested at phase 1
    for (int i = 0; i < 40 && !(m_act && m_ph == 1); i++) tick();
    req(1'b0, 15'h1234, 8'h00);
    c0 = cyc; got = 0; r1 = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (cpu_ready) begin got = 1; r1 = cyc; end
    end
    cpu_req = 1'b0;
    chk("rd_ready_seen", got, 1);
    chk("rd_latency", r1 - c0, 6);
    chk("rd_data", cpu_rdata, 8'h5A);
`endif

    // blanking: back-to-back writes
    vblank_n = 1'b0;
    for (int i = 0; i < 20 && m_act; i++) tick();
    req(1'b1, 15'h0000, 8'h55);
    c0 = cyc; r1 = 0; r2 = 0;
    for (int i = 0; i < 30 && r2 == 0; i++) begin
      tick();
      if (cpu_ready) begin
        if (r1 == 0) begin
          r1 = cyc;
          req(1'b1, 15'h0001, 8'hAA);
        end else begin
          r2 = cyc;
          cpu_req = 1'b0;
        end
      end
    end
    chk("wr_latency", r1 - c0, 4);
    chk("wr_gap", r2 - r1, 5);
    chk("chip0", chip[0], 8'h55);
    chk("chip1", chip[1], 8'hAA);
    vblank_n = 1'b1;

`ifndef VRAM_ARB_VBLANK_ONLY_EN
    // misaligned shload_n during write strobe
    for (int i = 0; i < 40 && !(m_act && m_ph == 1); i++) tick();
    req(1'b1, 15'h0100, 8'h77);
    for (int i = 0; i < 10 && m_k != 1; i++) tick();
    shload_n = 1'b0;
    step();
    chk("mis_sync_err", sync_err, 1);
    chk("mis_we_n", ram_we_n, 1);
    chk("mis_ready", cpu_ready, 0);
    c1 = cyc; got = 0; r1 = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (cpu_ready) begin got = 1; r1 = cyc; end
    end
    cpu_req = 1'b0;
    chk("retry_seen", got, 1);
    chk("retry_latency", r1 - c1, 7);
    chk("retry_chip", chip[15'h0100], 8'h77);

    // request dropped after start still completes
    for (int i = 0; i < 40 && !(m_act && m_ph == 2); i++) tick();
    req(1'b0, 15'h0003, 8'h00);
    for (int i = 0; i < 10 && m_k != 0; i++) tick();
    cpu_req = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (cpu_ready) got = 1;
    end
    chk("drop_ready", got, 1);
`endif

    // reset in the middle of a read strobe
    vblank_n = 1'b0;
    for (int i = 0; i < 20 && m_act; i++) tick();
    req(1'b0, 15'h0005, 8'h00);
    for (int i = 0; i < 10 && m_k != 1; i++) tick();
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    chk("rst_oe_n", ram_oe_n, 1);
    chk("rst_we_n", ram_we_n, 1);
    chk("rst_ce_n", ram_ce_n, 1);
    chk("rst_bus_oe", cpu_bus_oe, 0);
    chk("rst_ready", cpu_ready, 0);
    step();
    step();
    rst = 1'b0;
    vblank_n = 1'b1;
    repeat (20) tick();

`ifdef VRAM_ARB_VBLANK_ONLY_EN
    // request in active display waits for blanking
    for (int i = 0; i < 40 && !(m_act && m_ph == 5); i++) tick();
    req(1'b1, 15'h0200, 8'h3C);
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (cpu_bus_oe) seen = 1;
    end
    chk("vo_no_bus", seen, 0);
    vblank_n = 1'b0;
    for (int i = 0; i < 20 && !(!m_act && m_ph == 0); i++) tick();
    c0 = cyc; got = 0; r1 = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (cpu_ready) begin got = 1; r1 = cyc; end
    end
    cpu_req = 1'b0;
    chk("vo_ready_seen", got, 1);
    chk("vo_latency", r1 - c0, 4);
    vblank_n = 1'b1;
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(49) == 0) vblank_n = ~vblank_n;
      if (!cpu_req && $urandom_range(3) == 0)
        req(1'($urandom), 15'($urandom_range(15)), 8'($urandom));
      if (m_ph != 7 && $urandom_range(79) == 0) begin
        shload_n = 1'b0;
        step();
      end else begin
        tick();
      end
      if (cpu_ready) cpu_req = 1'b0;
    end
    cpu_req = 1'b0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
